// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction counter and table entry.
// Combinational helpers only; no latency or flow control applies here.
// Tag field is sized for the smallest legal table; narrower tags are zero-extended.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        bp_ctr_e              ctr;
    } bp_entry_t;

    localparam bp_ctr_e CTR_INIT  = WNT;
    localparam bp_ctr_e CTR_ALLOC = WT;

    function automatic bp_ctr_e sat_update(input bp_ctr_e ctr, input logic taken);
        logic [1:0] raw;
        raw = ctr;
        if (taken) begin
            if (ctr != ST) raw = raw + 2'd1;
        end else begin
            if (ctr != SNT) raw = raw - 2'd1;
        end
        return bp_ctr_e'(raw);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolve and redirect signals between pipeline and predictor.
// Pure wiring: no latency; no backpressure (predictor always accepts).
// master = pipeline side, slave = predictor side.
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, flush, redirect_pc, stat_branches, stat_mispred
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, flush, redirect_pc, stat_branches, stat_mispred
    );

endinterface

// File: rtl/branch_predictor_table.sv
// BHT+BTB storage: ENTRIES entries, one combinational read port, one read-modify-write update port.
// Read latency 0; update lands on the next rising edge (reads see the pre-update entry).
// No backpressure: an update is applied every cycle upd_en is high.
module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output bp_entry_t            rd_entry,
    input  logic                 upd_en,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic [TAG_MAX_W-1:0] upd_tag,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target
);

    bp_entry_t mem [ENTRIES];
    logic      upd_hit;

    assign rd_entry = mem[rd_idx];
    assign upd_hit  = mem[upd_idx].valid && (mem[upd_idx].tag == upd_tag);

    // Hit trains the counter (target only moves on taken); a taken miss allocates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                mem[upd_idx].ctr <= sat_update(mem[upd_idx].ctr, upd_taken);
                if (upd_taken) mem[upd_idx].target <= upd_target;
            end else if (upd_taken) begin
                mem[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_ALLOC};
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BHT+BTB predictor with EX-stage training and mispredict redirect; BP_STATS_EN adds counters.
// Prediction is combinational (0 cycles); flush/redirect_pc are registered one cycle after resolve.
// No backpressure: resolves arriving while flush is high belong to squashed work and are dropped.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic [TAG_MAX_W-1:0] if_tag;
    logic [TAG_MAX_W-1:0] ex_tag;
    bp_entry_t            rd_entry;
    logic                 hit;
    logic                 accept;
    logic                 mispred;
    logic                 flush_q;
    logic [31:0]          redirect_q;
    logic                 unused_bits;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign if_tag = {{IDX_W{1'b0}}, bp.if_pc[31 -: TAG_W]};
    assign ex_tag = {{IDX_W{1'b0}}, bp.ex_pc[31 -: TAG_W]};

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (if_idx),
        .rd_entry   (rd_entry),
        .upd_en     (accept),
        .upd_idx    (ex_idx),
        .upd_tag    (ex_tag),
        .upd_taken  (bp.ex_taken),
        .upd_target (bp.ex_target)
    );

    assign hit            = rd_entry.valid && (rd_entry.tag == if_tag);
    assign bp.pred_taken  = hit & rd_entry.ctr[1];
    assign bp.pred_target = bp.pred_taken ? rd_entry.target : bp.if_pc + 32'd4;

    assign accept  = bp.ex_valid & ~flush_q;
    assign mispred = (bp.ex_taken != bp.ex_pred_taken) ||
                     (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q <= accept & mispred;
            if (accept & mispred) redirect_q <= bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
        end
    end

    assign bp.flush       = flush_q;
    assign bp.redirect_pc = redirect_q;

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else if (accept) begin
            if (branches_q != '1)           branches_q <= branches_q + 32'd1;
            if (mispred && mispred_q != '1) mispred_q  <= mispred_q + 32'd1;
        end
    end

    assign bp.stat_branches = branches_q;
    assign bp.stat_mispred  = mispred_q;
`else
    assign bp.stat_branches = '0;
    assign bp.stat_mispred  = '0;
`endif

    // Byte-offset bits and the counter's weak/strong bit do not affect the lookup.
    assign unused_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0], rd_entry.ctr[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table of lookups/resolves plus hand-written corner sequences.
// Expected flush/redirect per cycle are queued when stimulus is driven and popped after the clock edge.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_res;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_flush;
        logic [31:0] e_redir;
    } vec_t;

    typedef struct {
        logic        flush;
        logic [31:0] redir;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk_l(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        vec_t v;
        v = '{is_res: 1'b0, pc: pc, taken: 1'b0, tgt: '0, ptk: 1'b0, ptgt: '0,
              e_pt: pt, e_ptgt: ptgt, e_flush: 1'b0, e_redir: '0};
        return v;
    endfunction

    function automatic vec_t mk_r(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                  input logic ptk, input logic [31:0] ptgt,
                                  input logic ef, input logic [31:0] er);
        vec_t v;
        v = '{is_res: 1'b1, pc: pc, taken: taken, tgt: tgt, ptk: ptk, ptgt: ptgt,
              e_pt: 1'b0, e_ptgt: '0, e_flush: ef, e_redir: er};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic f, input logic [31:0] r);
        exp_t e;
        e.flush = f;
        e.redir = r;
        sb_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " flush"}, {31'd0, bp.flush}, {31'd0, e.flush});
            if (e.flush) chk({tag, " redirect_pc"}, bp.redirect_pc, e.redir);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic pt,
                          input logic [31:0] ptgt);
        bp.if_pc = pc;
        #1;
        chk({tag, " pred_taken"}, {31'd0, bp.pred_taken}, {31'd0, pt});
        chk({tag, " pred_target"}, bp.pred_target, ptgt);
        push_exp(1'b0, '0);
        tick(tag);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                           input logic ef, input logic [31:0] er);
        bp.ex_valid       = 1'b1;
        bp.ex_pc          = pc;
        bp.ex_taken       = taken;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = ptk;
        bp.ex_pred_target = ptgt;
        push_exp(ef, er);
        tick(tag);
        bp.ex_valid = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BP_STATS_EN
        chk({tag, " stat_branches"}, bp.stat_branches, br);
        chk({tag, " stat_mispred"}, bp.stat_mispred, mp);
`else
        chk({tag, " stat_branches"}, bp.stat_branches, 32'd0 & br);
        chk({tag, " stat_mispred"}, bp.stat_mispred, 32'd0 & mp);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n             = 1'b0;
        bp.if_pc          = 32'h100;
        bp.ex_valid       = 1'b0;
        bp.ex_pc          = '0;
        bp.ex_taken       = 1'b0;
        bp.ex_target      = '0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = '0;

        // Reset state.
        #12;
        chk("reset flush", {31'd0, bp.flush}, 32'd0);
        chk("reset redirect_pc", bp.redirect_pc, 32'd0);
        chk_stats("reset", 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Direction/target training, aliasing, wrap and saturation sequences.
        vecs.push_back(mk_l(32'h100, 1'b0, 32'h104));
        vecs.push_back(mk_r(32'h100, 1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h80));
        vecs.push_back(mk_l(32'h100, 1'b1, 32'h80));
        vecs.push_back(mk_r(32'h100, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0));
        vecs.push_back(mk_r(32'h100, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0));
        vecs.push_back(mk_l(32'h100, 1'b1, 32'h80));
        vecs.push_back(mk_r(32'h100, 1'b0, 32'h333, 1'b1, 32'h80,  1'b1, 32'h104));
        vecs.push_back(mk_l(32'h100, 1'b1, 32'h80));
        vecs.push_back(mk_r(32'h100, 1'b0, 32'h333, 1'b1, 32'h80,  1'b1, 32'h104));
        vecs.push_back(mk_l(32'h100, 1'b0, 32'h104));
        vecs.push_back(mk_r(32'h100, 1'b1, 32'h90,  1'b0, 32'h104, 1'b1, 32'h90));
        vecs.push_back(mk_l(32'h100, 1'b1, 32'h90));
        vecs.push_back(mk_r(32'h100, 1'b1, 32'hA0,  1'b1, 32'h90,  1'b1, 32'hA0));
        vecs.push_back(mk_l(32'h100, 1'b1, 32'hA0));
        vecs.push_back(mk_l(32'h200, 1'b0, 32'h204));
        vecs.push_back(mk_r(32'h200, 1'b1, 32'h40,  1'b0, 32'h204, 1'b1, 32'h40));
        vecs.push_back(mk_l(32'h200, 1'b1, 32'h40));
        vecs.push_back(mk_l(32'h100, 1'b0, 32'h104));
        vecs.push_back(mk_r(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 32'h0));
        vecs.push_back(mk_l(32'hFFFF_FFFC, 1'b0, 32'h0));
        vecs.push_back(mk_r(32'h400, 1'b1, 32'h20,  1'b0, 32'h404, 1'b1, 32'h20));
        vecs.push_back(mk_l(32'h400, 1'b1, 32'h20));
        vecs.push_back(mk_r(32'h400, 1'b0, 32'h555, 1'b1, 32'h20,  1'b1, 32'h404));
        vecs.push_back(mk_l(32'h400, 1'b0, 32'h404));
        vecs.push_back(mk_r(32'h400, 1'b0, 32'h555, 1'b0, 32'h404, 1'b0, 32'h0));
        vecs.push_back(mk_r(32'h400, 1'b0, 32'h555, 1'b0, 32'h404, 1'b0, 32'h0));
        vecs.push_back(mk_r(32'h400, 1'b1, 32'h20,  1'b0, 32'h404, 1'b1, 32'h20));
        vecs.push_back(mk_l(32'h400, 1'b0, 32'h404));
        vecs.push_back(mk_r(32'h400, 1'b1, 32'h20,  1'b0, 32'h404, 1'b1, 32'h20));
        vecs.push_back(mk_l(32'h400, 1'b1, 32'h20));
        // Second resolve lands while flush is high and must be dropped.
        vecs.push_back(mk_r(32'h504, 1'b1, 32'h60,  1'b0, 32'h508, 1'b1, 32'h60));
        vecs.push_back(mk_r(32'h508, 1'b1, 32'h70,  1'b0, 32'h50C, 1'b0, 32'h0));
        vecs.push_back(mk_l(32'h508, 1'b0, 32'h50C));
        vecs.push_back(mk_l(32'h504, 1'b1, 32'h60));
        vecs.push_back(mk_r(32'h700, 1'b0, 32'h0,   1'b0, 32'h704, 1'b0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_res)
                resolve($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].tgt,
                        vecs[i].ptk, vecs[i].ptgt, vecs[i].e_flush, vecs[i].e_redir);
            else
                lookup($sformatf("vec%0d", i), vecs[i].pc, vecs[i].e_pt, vecs[i].e_ptgt);
        end

        // Same-cycle lookup and update to one index sees the old entry.
        bp.if_pc          = 32'h60C;
        bp.ex_valid       = 1'b1;
        bp.ex_pc          = 32'h60C;
        bp.ex_taken       = 1'b1;
        bp.ex_target      = 32'h44;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = 32'h610;
        #1;
        chk("nobypass pre pred_taken", {31'd0, bp.pred_taken}, 32'd0);
        chk("nobypass pre pred_target", bp.pred_target, 32'h610);
        push_exp(1'b1, 32'h44);
        tick("nobypass");
        bp.ex_valid = 1'b0;
        #1;
        chk("nobypass post pred_taken", {31'd0, bp.pred_taken}, 32'd1);
        chk("nobypass post pred_target", bp.pred_target, 32'h44);
        push_exp(1'b0, '0);
        tick("nobypass drain");

        // Fresh reset, then 10 accepted resolves with 3 mispredicts; dropped resolves do not count.
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        chk_stats("stats reset", 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(4 * i);
            if (i == 0 || i == 3 || i == 6) begin
                resolve($sformatf("stats%0d", i), pc, 1'b0, 32'h0, 1'b1, 32'h1, 1'b1, pc + 32'd4);
                resolve($sformatf("stats%0d drop", i), pc, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
            end else begin
                resolve($sformatf("stats%0d", i), pc, 1'b0, 32'h0, 1'b0, pc + 32'd4, 1'b0, 32'h0);
            end
        end
        chk_stats("stats after 10", 32'd10, 32'd3);

        // Asynchronous reset while flush is high clears outputs and the table.
        resolve("midrst alloc", 32'h2000, 1'b1, 32'h3000, 1'b0, 32'h2004, 1'b1, 32'h3000);
        bp.if_pc = 32'h2000;
        #1;
        chk("midrst pre pred_taken", {31'd0, bp.pred_taken}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst flush", {31'd0, bp.flush}, 32'd0);
        chk("midrst redirect_pc", bp.redirect_pc, 32'd0);
        chk("midrst pred_taken", {31'd0, bp.pred_taken}, 32'd0);
        chk("midrst pred_target", bp.pred_target, 32'h2004);
        chk_stats("midrst", 32'd0, 32'd0);
        sb_q.delete();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
